// File: rtl/apb_requester.sv
// APB4 requester: turns single-beat controller commands into APB setup/access
// transfers and returns read data and error status on a valid/ready channel.
module apb_requester #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_I  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]           wait_q, wait_d;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pstrb_d       = pstrb_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_d        = wait_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          pstrb_d   = cmd_write ? cmd_strb : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready on the final wait cycle still beats the timeout
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (TIMEOUT_CYCLES > 0 && wait_q == TO_LAST) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pstrb_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pstrb_q       <= pstrb_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_q        <= wait_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE) && !rst;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pstrb       = pstrb_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed scenarios plus random
// transfers compared against a transaction-level response model.
module tb_apb_requester;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          accessCycles;
    logic [DW-1:0] rdata;
    logic        err;
    logic        timeout;
  } expect_t;

  apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // Response rules: a peripheral stalling TO or more cycles is aborted.
  function automatic expect_t modelResponse(input logic isWrite, input int waits,
                                            input logic [DW-1:0] rd, input logic slv);
    expect_t e;
    logic timedOut;
    timedOut       = (waits >= TO);
    e.accessCycles = timedOut ? TO : waits + 1;
    e.rdata        = (timedOut || isWrite) ? '0 : rd;
    e.err          = timedOut ? 1'b1 : slv;
    e.timeout      = timedOut;
    return e;
  endfunction

  task automatic applyStimulus(input logic isWrite, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wd, input logic [SW-1:0] strb,
                               input int waits, input logic [DW-1:0] rd,
                               input logic slv, input int rspDelay);
    expect_t e;
    int cycles;
    logic [DW-1:0] expWdata;
    logic [SW-1:0] expStrb;
    logic [DW-1:0] heldRdata;
    e        = modelResponse(isWrite, waits, rd, slv);
    expWdata = isWrite ? wd : '0;
    expStrb  = isWrite ? strb : '0;

    checkOutput("idleReady", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = isWrite; cmd_addr = addr;
    cmd_wdata = wd;   cmd_strb = strb;     pready = 1'b0;
    tick;
    cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = AW'($urandom);
    checkOutput("setupPsel", psel, 1);
    checkOutput("setupPenable", penable, 0);
    checkOutput("setupPaddr", paddr, addr);
    checkOutput("setupPwrite", pwrite, isWrite);
    checkOutput("setupPwdata", pwdata, expWdata);
    checkOutput("setupPstrb", pstrb, expStrb);
    checkOutput("busyReady", cmd_ready, 0);
    tick;
    checkOutput("accessPenable", penable, 1);

    cycles = 0;
    for (int c = 1; c <= 20; c++) begin
      pready  = (c == waits + 1);
      prdata  = pready ? rd : $urandom;
      pslverr = pready ? slv : 1'($urandom);
      tick;
      cycles = c;
      if (rsp_valid) break;
      checkOutput("waitPenable", penable, 1);
      checkOutput("waitPsel", psel, 1);
      checkOutput("waitPaddr", paddr, addr);
      checkOutput("waitPstrb", pstrb, expStrb);
      checkOutput("waitPwdata", pwdata, expWdata);
    end
    pready = 1'b0; pslverr = 1'b0;

    checkOutput("rspValid", rsp_valid, 1);
    checkOutput("accessCycles", cycles, e.accessCycles);
    checkOutput("rspPsel", psel, 0);
    checkOutput("rspPenable", penable, 0);
    checkOutput("rspRdata", rsp_rdata, e.rdata);
    checkOutput("rspErr", rsp_err, e.err);
    checkOutput("rspTimeout", rsp_timeout, e.timeout);
    checkOutput("rspPaddrHeld", paddr, addr);
    heldRdata = rsp_rdata;

    // Commands offered while a response is pending must be ignored
    rsp_ready = 1'b0;
    for (int d = 0; d < rspDelay; d++) begin
      cmd_valid = 1'b1;
      tick;
      checkOutput("bpValid", rsp_valid, 1);
      checkOutput("bpRdata", rsp_rdata, heldRdata);
      checkOutput("bpErr", rsp_err, e.err);
      checkOutput("bpTimeout", rsp_timeout, e.timeout);
      checkOutput("bpCmdReady", cmd_ready, 0);
      checkOutput("bpPsel", psel, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checkOutput("doneValid", rsp_valid, 0);
    checkOutput("doneReady", cmd_ready, 1);
    checkOutput("donePsel", psel, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepts[$];
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0; prdata = '0;
    pready = 1'b0; pslverr = 1'b0;
    repeat (3) tick;
    checkOutput("rstPsel", psel, 0);
    checkOutput("rstPenable", penable, 0);
    checkOutput("rstPaddr", paddr, 0);
    checkOutput("rstPwdata", pwdata, 0);
    checkOutput("rstPstrb", pstrb, 0);
    checkOutput("rstPwrite", pwrite, 0);
    checkOutput("rstRspValid", rsp_valid, 0);
    checkOutput("rstRspRdata", rsp_rdata, 0);
    checkOutput("rstRspErr", rsp_err, 0);
    checkOutput("rstRspTimeout", rsp_timeout, 0);
    checkOutput("rstCmdReady", cmd_ready, 0);
    rst = 1'b0;
    tick;

    applyStimulus(1'b1, 16'h0000, 32'h12345678, 4'b1111, 0, 32'h0, 1'b0, 0);
    applyStimulus(1'b0, 16'h0008, 32'hdeadbeef, 4'b1010, 3, 32'h90abcdef, 1'b0, 1);
    applyStimulus(1'b0, 16'h00FC, 32'h0, 4'b0000, 0, 32'h55aa55aa, 1'b1, 0);
    applyStimulus(1'b0, 16'h0010, 32'h0, 4'b0000, 30, 32'h11111111, 1'b0, 0);
    applyStimulus(1'b0, 16'h0014, 32'h0, 4'b0000, TO - 1, 32'hcafef00d, 1'b0, 0);
    applyStimulus(1'b1, 16'h0020, 32'ha5a5a5a5, 4'b0011, 2, 32'h0, 1'b1, 5);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                    int'($urandom_range(0, TO + 2)), $urandom,
                    1'($urandom), int'($urandom_range(0, 3)));
    end

    // Back-to-back writes with a responder and consumer that never stall
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0040;
    cmd_wdata = 32'h0badf00d; cmd_strb = 4'b1111;
    pready = 1'b1; rsp_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (cmd_ready) accepts.push_back(n);
      tick;
    end
    cmd_valid = 1'b0;
    repeat (4) tick;
    pready = 1'b0; rsp_ready = 1'b0;
    checkOutput("b2bCount", (accepts.size() >= 2) ? 1 : 0, 1);
    if (accepts.size() >= 2) checkOutput("b2bSpacing", accepts[1] - accepts[0], 4);
    checkOutput("b2bIdle", cmd_ready, 1);

    // Reset asserted while the access phase is active
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0030;
    tick;
    cmd_valid = 1'b0;
    tick;
    checkOutput("midPenable", penable, 1);
    rst = 1'b1;
    #1;
    checkOutput("midRstPsel", psel, 0);
    checkOutput("midRstPenable", penable, 0);
    checkOutput("midRstValid", rsp_valid, 0);
    tick;
    rst = 1'b0;
    tick;
    checkOutput("postRstReady", cmd_ready, 1);
    applyStimulus(1'b0, 16'h0034, 32'h0, 4'b0000, 1, 32'h76543210, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
